hazard_unit: RTL and testbench
==============================

# hazard_unit

Generates the per-stage `stall`, `flush` and `extend` vectors consumed by `pipe_unit` for the 5-stage core. It detects load-use hazards, flushes on taken branches and MEM-stage exceptions, and holds EX for multi-cycle multiply/divide operations using an internal counter FSM. It also holds MEM while the data memory reports busy. Bit index follows the pipe convention throughout: 0=WB, 1=MEM, 2=EX, 3=ID, 4=IF.

## Interface
- `MUL_CYCLES`, 4, total EX occupancy of a multiply (≥1)
- `DIV_CYCLES`, 32, total EX occupancy of a divide (≥1)
- `clk`  in  1  clock, rising edge
- `rst`  in  1  synchronous, active-high reset
- `id_valid`, `ex_valid`, `mem_valid`  in  1 each  stage holds a real instruction (registered in the pipeline registers)
- `id_rs`, `id_rt`  in  5 each  ID source registers
- `id_uses_rs`, `id_uses_rt`  in  1 each  ID reads that source
- `ex_rd`  in  5  EX destination register
- `ex_mem_read`  in  1  EX instruction is a load
- `ex_branch_taken`  in  1  EX branch resolved taken
- `ex_mdu_start`  in  1  EX instruction is a mult/div
- `ex_mdu_div`  in  1  1=divide, 0=multiply
- `mem_busy`  in  1  data memory not ready this cycle
- `mem_exception`  in  1  MEM instruction raised an exception
- `stall`  out  5  to `pipe_unit`
- `flush`  out  5  to `pipe_unit`
- `extend`  out  5  to `pipe_unit`
- `mdu_busy`  out  1  MDU FSM not IDLE

## Operation
- Outputs are combinational from inputs plus registered FSM state. Bits not listed below are constant 0.
- `exc = mem_exception & mem_valid`.
- `extend[1] = mem_busy & mem_valid & !exc`.
- `ex_adv = !extend[1] & !extend[2]`, meaning EX leaves this cycle.
- Load-use: `stall[3] = !exc & id_valid & ex_valid & ex_mem_read & ex_rd!=0 & ((id_uses_rs & id_rs==ex_rd) | (id_uses_rt & id_rt==ex_rd))`.
- Branch: `flush[3] = !exc & ex_valid & ex_branch_taken & ex_adv`. The flush fires once, on the cycle EX advances.
- Exception: `flush[1] = exc`. While `exc` is high, `stall` and `extend` are all 0 and the MDU FSM aborts to IDLE.
- MDU FSM. N = `DIV_CYCLES` if `ex_mdu_div`, else `MUL_CYCLES`. `cnt` is sized clog2(max(MUL_CYCLES, DIV_CYCLES)).
  - IDLE: on `ex_valid & ex_mdu_start & !exc`:
    - if N≥2: `extend[2]=1` this cycle, `cnt<=N-2`, go to BUSY.
    - if N=1: no extend; go to DONE if `!ex_adv`, otherwise stay IDLE.
  - BUSY: if `cnt!=0`, `extend[2]=1` and `cnt<=cnt-1`. If `cnt==0`, `extend[2]=0`; go to IDLE if `ex_adv`, else DONE. The start input is ignored in BUSY.
  - DONE: `extend[2]=0`. Go to IDLE when `ex_adv`. The start input is ignored, so a held instruction never restarts the MDU.
  - The counter keeps running while EX is also held by `extend[1]`.
- `mdu_busy = (state!=IDLE)`.

## Timing
- Reset: state=IDLE, `cnt`=0. With all `*_valid`=0, every output is 0.
- Reset asserted mid-operation returns the FSM to IDLE on the next edge.
- Zero-latency decisions: load-use, branch and exception outputs appear in the same cycle as their inputs.
- An MDU op of N cycles asserts `extend[2]` for exactly N-1 consecutive cycles (the start cycle through start+N-2). It deasserts in cycle N when no MEM hold is present.
- Simultaneous events:
  - An exception overrides everything.
  - A load-use stall together with `extend[1]` or `extend[2]` is allowed; both are output.
  - A taken branch held in EX by `mem_busy` delays `flush[3]` until `mem_busy` drops.

## Test plan
- Load-use: `ex_mem_read=1`, `ex_rd=5`, `id_rs=5`, `id_uses_rs=1`, all valid -> `stall=5'b01000` for 1 cycle. With `ex_rd=0`, `stall=0`.
- Multiply, defaults: `ex_mdu_start=1`, `ex_mdu_div=0` held 4 cycles -> `extend=5'b00100` in cycles 1–3, 0 in cycle 4, FSM back to IDLE. For a divide, `extend[2]` stays high for 31 cycles.
- MDU finishing under a MEM hold: `mem_busy=1` during cycles 3–6 of a multiply -> FSM enters DONE, `extend[2]=0`, `extend[1]=1`. It returns to IDLE on the first cycle with `mem_busy=0`, with no restart.
- Taken branch with `mem_busy=1` for 2 cycles -> `flush=0` for those 2 cycles, then `flush=5'b01000` exactly once.
- Exception during a divide (cycle 10): `mem_exception=1` -> `flush=5'b00010`, `stall=extend=0`, `mdu_busy=0` on the next cycle.
- `rst=1` mid-divide -> `mdu_busy=0` after the edge. The next `ex_mdu_start` begins a fresh full count.

Source files
------------

// File: rtl/hazard_unit_if.sv
// Hazard-control bundle between the pipeline datapath (master) and hazard_unit (slave).
// Stage bit index on the 5-bit vectors: 0=WB, 1=MEM, 2=EX, 3=ID, 4=IF.
interface hazard_unit_if;
    logic       id_valid;
    logic       ex_valid;
    logic       mem_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rs;
    logic       id_uses_rt;
    logic [4:0] ex_rd;
    logic       ex_mem_read;
    logic       ex_branch_taken;
    logic       ex_mdu_start;
    logic       ex_mdu_div;
    logic       mem_busy;
    logic       mem_exception;
    logic [4:0] stall;
    logic [4:0] flush;
    logic [4:0] extend;
    logic       mdu_busy;

    modport master (
        output id_valid, ex_valid, mem_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
               ex_rd, ex_mem_read, ex_branch_taken, ex_mdu_start, ex_mdu_div,
               mem_busy, mem_exception,
        input  stall, flush, extend, mdu_busy
    );

    modport slave (
        input  id_valid, ex_valid, mem_valid, id_rs, id_rt, id_uses_rs, id_uses_rt,
               ex_rd, ex_mem_read, ex_branch_taken, ex_mdu_start, ex_mdu_div,
               mem_busy, mem_exception,
        output stall, flush, extend, mdu_busy
    );
endinterface

// File: rtl/hazard_unit.sv
// Per-stage stall/flush/extend generation for the 5-stage core: load-use, taken branch,
// MEM exception, data-memory wait and a counter FSM holding EX for multi-cycle mul/div.
module hazard_unit #(
    parameter int MUL_CYCLES = 4,
    parameter int DIV_CYCLES = 32
) (
    input  logic          clk,
    input  logic          rst,
    hazard_unit_if.slave  hz
);
    localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = ($clog2(MAX_CYCLES) < 1) ? 1 : $clog2(MAX_CYCLES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } mdu_state_t;

    mdu_state_t       state_r;
    logic [CNT_W-1:0] cnt_r;

    logic        exc_s;
    logic        ext_mem_s;
    logic        ext_ex_s;
    logic        ex_adv_s;
    logic        mdu_go_s;
    logic        load_use_s;
    logic        branch_flush_s;
    logic [31:0] n_cycles_s;

    assign exc_s     = hz.mem_exception & hz.mem_valid;
    assign ext_mem_s = hz.mem_busy & hz.mem_valid & ~exc_s;
    assign mdu_go_s  = hz.ex_valid & hz.ex_mdu_start & ~exc_s;
    assign ex_adv_s  = ~ext_mem_s & ~ext_ex_s;

    // Occupancy of the operation currently sitting in EX
    always_comb begin
        n_cycles_s = 32'(MUL_CYCLES);
        if (hz.ex_mdu_div) begin
            n_cycles_s = 32'(DIV_CYCLES);
        end else begin
            n_cycles_s = 32'(MUL_CYCLES);
        end
    end

    // EX hold request from the MDU; a one-cycle op never holds EX
    always_comb begin
        ext_ex_s = 1'b0;
        if (exc_s) begin
            ext_ex_s = 1'b0;
        end else begin
            case (state_r)
                IDLE:    ext_ex_s = mdu_go_s & (n_cycles_s >= 32'd2);
                BUSY:    ext_ex_s = (cnt_r != {CNT_W{1'b0}});
                default: ext_ex_s = 1'b0;
            endcase
        end
    end

    // Load-use hazard against the load in EX
    always_comb begin
        load_use_s = 1'b0;
        if (!exc_s && hz.id_valid && hz.ex_valid && hz.ex_mem_read && (hz.ex_rd != 5'd0)) begin
            load_use_s = (hz.id_uses_rs && (hz.id_rs == hz.ex_rd)) ||
                         (hz.id_uses_rt && (hz.id_rt == hz.ex_rd));
        end else begin
            load_use_s = 1'b0;
        end
    end

    // A held branch flushes only on the cycle it actually leaves EX
    assign branch_flush_s = ~exc_s & hz.ex_valid & hz.ex_branch_taken & ex_adv_s;

    assign hz.stall    = {1'b0, load_use_s, 3'b000};
    assign hz.flush    = {1'b0, branch_flush_s, 1'b0, exc_s, 1'b0};
    assign hz.extend   = {2'b00, ext_ex_s, ext_mem_s, 1'b0};
    assign hz.mdu_busy = (state_r != IDLE);

    // MDU counter FSM; DONE parks a finished op until EX is free to advance
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
        end else if (exc_s) begin
            state_r <= IDLE;
            cnt_r   <= {CNT_W{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (mdu_go_s) begin
                        if (n_cycles_s >= 32'd2) begin
                            state_r <= BUSY;
                            cnt_r   <= CNT_W'(n_cycles_s - 32'd2);
                        end else if (!ex_adv_s) begin
                            state_r <= DONE;
                        end else begin
                            state_r <= IDLE;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                BUSY: begin
                    if (cnt_r != {CNT_W{1'b0}}) begin
                        cnt_r <= cnt_r - CNT_W'(1);
                    end else if (ex_adv_s) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                DONE: begin
                    if (ex_adv_s) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= {CNT_W{1'b0}};
                end
            endcase
        end
    end
endmodule

// File: tb/tb_hazard_unit.sv
// Self-checking bench for hazard_unit: directed scenarios plus randomized traffic
// compared against an occupancy-countdown reference model.
module tb_hazard_unit;
    localparam int MUL_N = 4;
    localparam int DIV_N = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    hazard_unit_if hif();

    hazard_unit #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hif)
    );

    task automatic clear_inputs();
        hif.id_valid = 1'b0;        hif.ex_valid = 1'b0;       hif.mem_valid = 1'b0;
        hif.id_rs = 5'd0;           hif.id_rt = 5'd0;          hif.id_uses_rs = 1'b0;
        hif.id_uses_rt = 1'b0;      hif.ex_rd = 5'd0;          hif.ex_mem_read = 1'b0;
        hif.ex_branch_taken = 1'b0; hif.ex_mdu_start = 1'b0;   hif.ex_mdu_div = 1'b0;
        hif.mem_busy = 1'b0;        hif.mem_exception = 1'b0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if (hif.stall !== 5'b00000 || hif.flush !== 5'b00000 || hif.extend !== 5'b00000) begin
            errors++;
            $display("FAIL reset_vectors got stall=%b flush=%b extend=%b want all 00000", hif.stall, hif.flush, hif.extend);
        end
        checks++;
        if (hif.mdu_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mdu_busy got %b want 0", hif.mdu_busy);
        end
        next_cycle();
    endtask

    task automatic test_load_use();
        do_reset();
        hif.id_valid = 1'b1; hif.ex_valid = 1'b1; hif.ex_mem_read = 1'b1;
        hif.ex_rd = 5'd5; hif.id_rs = 5'd5; hif.id_uses_rs = 1'b1;
        @(negedge clk);
        checks++;
        if (hif.stall !== 5'b01000 || hif.extend !== 5'b00000) begin
            errors++;
            $display("FAIL load_use_rs got stall=%b extend=%b want 01000 00000", hif.stall, hif.extend);
        end
        next_cycle();
        hif.ex_rd = 5'd0; hif.id_rs = 5'd0;
        @(negedge clk);
        checks++;
        if (hif.stall !== 5'b00000) begin
            errors++;
            $display("FAIL load_use_r0 got %b want 00000", hif.stall);
        end
        next_cycle();
        hif.ex_rd = 5'd7; hif.id_rs = 5'd7; hif.id_uses_rs = 1'b0; hif.id_rt = 5'd3; hif.id_uses_rt = 1'b1;
        @(negedge clk);
        checks++;
        if (hif.stall !== 5'b00000) begin
            errors++;
            $display("FAIL load_use_unused_rs got %b want 00000", hif.stall);
        end
        next_cycle();
        hif.id_rt = 5'd7;
        @(negedge clk);
        checks++;
        if (hif.stall !== 5'b01000) begin
            errors++;
            $display("FAIL load_use_rt got %b want 01000", hif.stall);
        end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_multiply();
        do_reset();
        hif.ex_valid = 1'b1; hif.ex_mdu_start = 1'b1; hif.ex_mdu_div = 1'b0;
        for (int c = 1; c <= MUL_N; c++) begin
            @(negedge clk);
            checks++;
            if (hif.extend !== ((c <= MUL_N - 1) ? 5'b00100 : 5'b00000)) begin
                errors++;
                $display("FAIL mul_extend cycle %0d got %b", c, hif.extend);
            end
            next_cycle();
        end
        clear_inputs();
        @(negedge clk);
        checks++;
        if (hif.mdu_busy !== 1'b0) begin
            errors++;
            $display("FAIL mul_idle got mdu_busy=%b want 0", hif.mdu_busy);
        end
        next_cycle();
    endtask

    task automatic test_divide();
        int high_cnt;
        do_reset();
        high_cnt = 0;
        hif.ex_valid = 1'b1; hif.ex_mdu_start = 1'b1; hif.ex_mdu_div = 1'b1;
        for (int c = 1; c <= DIV_N; c++) begin
            @(negedge clk);
            if (hif.extend[2] === 1'b1) high_cnt++;
            if (c == DIV_N) begin
                checks++;
                if (hif.extend !== 5'b00000) begin
                    errors++;
                    $display("FAIL div_last_cycle got %b want 00000", hif.extend);
                end
            end
            next_cycle();
        end
        checks++;
        if (high_cnt != DIV_N - 1) begin
            errors++;
            $display("FAIL div_extend_count got %0d want %0d", high_cnt, DIV_N - 1);
        end
        clear_inputs();
    endtask

    task automatic test_mdu_mem_hold();
        logic [4:0] exp_ext [0:6] = '{5'b00100, 5'b00100, 5'b00110, 5'b00010, 5'b00010, 5'b00010, 5'b00000};
        logic [6:0] exp_busy = 7'b1111110;
        do_reset();
        hif.ex_valid = 1'b1; hif.ex_mdu_start = 1'b1; hif.ex_mdu_div = 1'b0; hif.mem_valid = 1'b1;
        for (int c = 0; c < 7; c++) begin
            hif.mem_busy = (c >= 2 && c <= 5) ? 1'b1 : 1'b0;
            @(negedge clk);
            checks++;
            if (hif.extend !== exp_ext[c] || hif.mdu_busy !== exp_busy[c]) begin
                errors++;
                $display("FAIL mdu_mem_hold cycle %0d got extend=%b busy=%b want %b %b",
                         c + 1, hif.extend, hif.mdu_busy, exp_ext[c], exp_busy[c]);
            end
            next_cycle();
        end
        clear_inputs();
        @(negedge clk);
        checks++;
        if (hif.mdu_busy !== 1'b0) begin
            errors++;
            $display("FAIL mdu_mem_hold_idle got %b want 0", hif.mdu_busy);
        end
        next_cycle();
    endtask

    task automatic test_branch_hold();
        do_reset();
        hif.ex_valid = 1'b1; hif.ex_branch_taken = 1'b1; hif.mem_valid = 1'b1;
        for (int c = 0; c < 3; c++) begin
            hif.mem_busy = (c < 2) ? 1'b1 : 1'b0;
            @(negedge clk);
            checks++;
            if (hif.flush !== ((c < 2) ? 5'b00000 : 5'b01000)) begin
                errors++;
                $display("FAIL branch_hold cycle %0d got flush=%b", c + 1, hif.flush);
            end
            next_cycle();
        end
        hif.ex_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (hif.flush !== 5'b00000) begin
            errors++;
            $display("FAIL branch_once got flush=%b want 00000", hif.flush);
        end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_exception();
        do_reset();
        hif.ex_valid = 1'b1; hif.ex_mdu_start = 1'b1; hif.ex_mdu_div = 1'b1;
        repeat (9) next_cycle();
        hif.mem_valid = 1'b1; hif.mem_exception = 1'b1; hif.mem_busy = 1'b1;
        hif.id_valid = 1'b1; hif.ex_mem_read = 1'b1; hif.ex_rd = 5'd4; hif.id_rs = 5'd4;
        hif.id_uses_rs = 1'b1; hif.ex_branch_taken = 1'b1;
        @(negedge clk);
        checks++;
        if (hif.flush !== 5'b00010 || hif.stall !== 5'b00000 || hif.extend !== 5'b00000) begin
            errors++;
            $display("FAIL exception got flush=%b stall=%b extend=%b want 00010 00000 00000", hif.flush, hif.stall, hif.extend);
        end
        next_cycle();
        clear_inputs();
        @(negedge clk);
        checks++;
        if (hif.mdu_busy !== 1'b0 || hif.extend !== 5'b00000) begin
            errors++;
            $display("FAIL exception_abort got busy=%b extend=%b want 0 00000", hif.mdu_busy, hif.extend);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid_div();
        int high_cnt;
        do_reset();
        hif.ex_valid = 1'b1; hif.ex_mdu_start = 1'b1; hif.ex_mdu_div = 1'b1;
        repeat (5) next_cycle();
        rst = 1'b1;
        next_cycle();
        rst = 1'b0;
        hif.ex_valid = 1'b0; hif.ex_mdu_start = 1'b0;
        @(negedge clk);
        checks++;
        if (hif.mdu_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_div got busy=%b want 0", hif.mdu_busy);
        end
        next_cycle();
        high_cnt = 0;
        hif.ex_valid = 1'b1; hif.ex_mdu_start = 1'b1;
        for (int c = 1; c <= DIV_N; c++) begin
            @(negedge clk);
            if (hif.extend[2] === 1'b1) high_cnt++;
            next_cycle();
        end
        checks++;
        if (high_cnt != DIV_N - 1) begin
            errors++;
            $display("FAIL restart_count got %0d want %0d", high_cnt, DIV_N - 1);
        end
        clear_inputs();
    endtask

    task automatic test_random();
        bit         m_active;
        int         m_left;
        bit         exc, e1, e2, adv, starting, ld_use, br;
        int         n, left;
        logic [4:0] w_stall, w_flush, w_ext;
        do_reset();
        m_active = 1'b0;
        m_left   = 0;
        for (int c = 0; c < 4000; c++) begin
            rst                 = ($urandom_range(0, 199) == 0);
            hif.id_valid        = ($urandom_range(0, 3) != 0);
            hif.ex_valid        = ($urandom_range(0, 3) != 0);
            hif.mem_valid       = ($urandom_range(0, 1) != 0);
            hif.id_rs           = 5'($urandom_range(0, 3));
            hif.id_rt           = 5'($urandom_range(0, 3));
            hif.id_uses_rs      = ($urandom_range(0, 1) != 0);
            hif.id_uses_rt      = ($urandom_range(0, 1) != 0);
            hif.ex_rd           = 5'($urandom_range(0, 3));
            hif.ex_mem_read     = ($urandom_range(0, 1) != 0);
            hif.ex_branch_taken = ($urandom_range(0, 2) == 0);
            hif.ex_mdu_start    = ($urandom_range(0, 3) == 0);
            hif.ex_mdu_div      = ($urandom_range(0, 3) == 0);
            hif.mem_busy        = ($urandom_range(0, 3) == 0);
            hif.mem_exception   = ($urandom_range(0, 63) == 0);
            @(negedge clk);
            exc      = hif.mem_exception && hif.mem_valid;
            e1       = hif.mem_busy && hif.mem_valid && !exc;
            n        = hif.ex_mdu_div ? DIV_N : MUL_N;
            starting = !m_active && hif.ex_valid && hif.ex_mdu_start && !exc;
            left     = m_active ? m_left : (starting ? n : 0);
            e2       = !exc && (m_active || starting) && (left > 1);
            adv      = !e1 && !e2;
            ld_use   = !exc && hif.id_valid && hif.ex_valid && hif.ex_mem_read && (hif.ex_rd != 5'd0) &&
                       ((hif.id_uses_rs && hif.id_rs == hif.ex_rd) || (hif.id_uses_rt && hif.id_rt == hif.ex_rd));
            br       = !exc && hif.ex_valid && hif.ex_branch_taken && adv;
            w_stall  = ld_use ? 5'b01000 : 5'b00000;
            w_flush  = (br ? 5'b01000 : 5'b00000) | (exc ? 5'b00010 : 5'b00000);
            w_ext    = (e2 ? 5'b00100 : 5'b00000) | (e1 ? 5'b00010 : 5'b00000);
            checks++;
            if (hif.stall !== w_stall || hif.flush !== w_flush || hif.extend !== w_ext ||
                hif.mdu_busy !== m_active) begin
                errors++;
                if (errors < 20)
                    $display("FAIL random cycle %0d got s=%b f=%b e=%b b=%b want s=%b f=%b e=%b b=%b",
                             c, hif.stall, hif.flush, hif.extend, hif.mdu_busy, w_stall, w_flush, w_ext, m_active);
            end
            next_cycle();
            if (rst || exc) begin
                m_active = 1'b0;
            end else if (m_active || starting) begin
                if (left > 1) begin
                    m_active = 1'b1;
                    m_left   = left - 1;
                end else begin
                    m_active = !adv;
                    m_left   = 1;
                end
            end else begin
                m_active = 1'b0;
            end
        end
        rst = 1'b0;
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        test_reset();
        test_load_use();
        test_multiply();
        test_divide();
        test_mdu_mem_hold();
        test_branch_hold();
        test_exception();
        test_reset_mid_div();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
